act_quant_bit_seq: RTL and testbench

- Sequencing controller for the bit-serial activation-quantization catch stage.
- Accepts one LSB-first serial activation word per transaction and drives the bit-index select that steers each bit into the catch window.
- Captures the OUT_W-bit window starting at CATCH_START_BIT, applies optional round-half-up, and saturates if any bit above the window is set.
- Returns the quantized activation over a valid/ready handshake to the downstream packing stage.

---
 rtl/act_quant_bit_seq.sv | 130 +++++++++++++
 tb/tb_act_quant_bit_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/act_quant_bit_seq.sv
// Bit-serial activation quantizer sequencer: steers an LSB-first word into an
// OUT_W-bit catch window, applies optional round-half-up, and saturates on overflow.
module act_quant_bit_seq #(
    parameter int DATA_W          = 32,
    parameter int CATCH_START_BIT = 10,
    parameter int OUT_W           = 8,
    parameter int ROUND_EN        = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      bit_in,
    input  logic                      bit_valid,
    output logic                      in_ready,
    output logic [$clog2(DATA_W)-1:0] sel_out,
    output logic                      busy,
    output logic [OUT_W-1:0]          q_out,
    output logic                      sat_flag,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int SEL_W = $clog2(DATA_W);
    localparam logic [SEL_W-1:0] ROUND_SEL = SEL_W'(CATCH_START_BIT - 1);
    localparam logic [SEL_W-1:0] HI_SEL    = SEL_W'(CATCH_START_BIT + OUT_W - 1);
    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [OUT_W-1:0] win_q, win_d;
    logic             rnd_q, rnd_d;
    logic             ovf_q, ovf_d;
    logic [OUT_W-1:0] q_q, q_d;
    logic             sat_q, sat_d;
    logic             round_up;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        sel_d    = sel_q;
        win_d    = win_q;
        rnd_d    = rnd_q;
        ovf_d    = ovf_q;
        q_d      = q_q;
        sat_d    = sat_q;
        round_up = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    sel_d   = '0;
                    win_d   = '0;
                    rnd_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            S_SHIFT: begin
                if (bit_valid) begin
                    for (int k = 0; k < OUT_W; k++) begin
                        if (sel_q == SEL_W'(CATCH_START_BIT + k)) win_d[k] = bit_in;
                    end
                    if (sel_q == ROUND_SEL) rnd_d = bit_in;
                    if (sel_q > HI_SEL) ovf_d = ovf_q | bit_in;

                    if (sel_q == LAST_SEL) begin
                        // Result uses the updated window/overflow so the final bit counts.
                        state_d  = S_HOLD;
                        sel_d    = '0;
                        round_up = (ROUND_EN != 0) && rnd_d;
                        if (ovf_d || (round_up && (&win_d))) begin
                            q_d   = '1;
                            sat_d = 1'b1;
                        end else begin
                            q_d   = win_d + OUT_W'(round_up);
                            sat_d = 1'b0;
                        end
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        state_d = S_SHIFT;
                        sel_d   = '0;
                        win_d   = '0;
                        rnd_d   = 1'b0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            win_q   <= '0;
            rnd_q   <= 1'b0;
            ovf_q   <= 1'b0;
            q_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            win_q   <= win_d;
            rnd_q   <= rnd_d;
            ovf_q   <= ovf_d;
            q_q     <= q_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = (state_q == S_SHIFT);
    assign busy      = (state_q == S_SHIFT) || (state_q == S_HOLD);
    assign out_valid = (state_q == S_HOLD);
    assign sel_out   = sel_q;
    assign q_out     = q_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_act_quant_bit_seq.sv
// Directed bench for act_quant_bit_seq: a rounding and a truncating instance
// share all stimulus; results are compared against hand-computed tables.
module tb_act_quant_bit_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, busy, sat_flag, out_valid;
    logic [4:0] sel_out;
    logic [7:0] q_out;

    logic       in_ready_nr, busy_nr, sat_nr, out_valid_nr;
    logic [4:0] sel_nr;
    logic [7:0] q_nr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    act_quant_bit_seq #(.DATA_W(32), .CATCH_START_BIT(10), .OUT_W(8), .ROUND_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .in_ready(in_ready), .sel_out(sel_out), .busy(busy), .q_out(q_out),
        .sat_flag(sat_flag), .out_valid(out_valid), .out_ready(out_ready)
    );

    act_quant_bit_seq #(.DATA_W(32), .CATCH_START_BIT(10), .OUT_W(8), .ROUND_EN(0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .in_ready(in_ready_nr), .sel_out(sel_nr), .busy(busy_nr), .q_out(q_nr),
        .sat_flag(sat_nr), .out_valid(out_valid_nr), .out_ready(out_ready)
    );

    typedef struct {
        logic [31:0] word;
        logic        stall;
        logic [7:0]  q_re;
        logic        sat_re;
        logic [7:0]  q_tr;
        logic        sat_tr;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge while IDLE or HOLD-with-release; leaves the DUT in SHIFT at sel 0.
    task automatic begin_txn();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("enter_busy", busy, 1);
        check("enter_sel", sel_out, 0);
        check("enter_out_valid", out_valid, 0);
    endtask

    task automatic send_bits(input logic [31:0] word, input int n, input bit stall);
        int i = 0;
        int budget = 0;
        while (i < n && budget < 2000) begin
            check("shift_sel", sel_out, i);
            check("shift_in_ready", in_ready, 1);
            check("shift_out_valid", out_valid, 0);
            bit_in    = word[i];
            bit_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            budget++;
            if (bit_valid) i++;
        end
        bit_valid = 1'b0;
        if (i < n) check("bit_budget", i, n);
    endtask

    task automatic check_result(input logic [7:0] q_re, input logic sat_re,
                                input logic [7:0] q_tr, input logic sat_tr);
        check("res_out_valid", out_valid, 1);
        check("res_in_ready", in_ready, 0);
        check("res_sel_wrap", sel_out, 0);
        check("res_q_round", q_out, q_re);
        check("res_sat_round", sat_flag, sat_re);
        check("res_q_trunc", q_nr, q_tr);
        check("res_sat_trunc", sat_nr, sat_tr);
    endtask

    task automatic release_to_idle(input logic [7:0] q_re);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_out_valid", out_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_q_kept", q_out, q_re);
    endtask

    initial begin
        //          word          stall q_re   sat  q_tr   sat
        vecs[0] = '{32'h00001C00, 1'b0, 8'h07, 1'b0, 8'h07, 1'b0};
        vecs[1] = '{32'h00001E00, 1'b0, 8'h08, 1'b0, 8'h07, 1'b0};
        vecs[2] = '{32'h00040000, 1'b0, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{32'h0003FE00, 1'b0, 8'hFF, 1'b1, 8'hFF, 1'b0};
        vecs[4] = '{32'h0003FC00, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{32'h000003FF, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{32'h80000000, 1'b0, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{32'h00000000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[8] = '{32'h00001C00, 1'b1, 8'h07, 1'b0, 8'h07, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_q", q_out, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_sel", sel_out, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_start_busy", busy, 0);

        for (int v = 0; v < 9; v++) begin
            begin_txn();
            send_bits(vecs[v].word, 32, vecs[v].stall);
            check_result(vecs[v].q_re, vecs[v].sat_re, vecs[v].q_tr, vecs[v].sat_tr);
            release_to_idle(vecs[v].q_re);
        end

        // HOLD with out_ready low: outputs stable, start ignored.
        begin_txn();
        send_bits(32'h00001E00, 32, 1'b0);
        for (int c = 0; c < 5; c++) begin
            start = 1'b1;
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_q", q_out, 8'h08);
            check("hold_sel", sel_out, 0);
        end
        start = 1'b0;

        // Back-to-back: release and start in the same HOLD cycle.
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_in_ready", in_ready, 1);
        check("b2b_out_valid", out_valid, 0);
        check("b2b_sel", sel_out, 0);
        send_bits(32'h00000400, 32, 1'b0);
        check_result(8'h01, 1'b0, 8'h01, 1'b0);
        release_to_idle(8'h01);

        // Asynchronous reset mid-word discards the partial transaction.
        begin_txn();
        send_bits(32'hFFFFFFFF, 15, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_sel", sel_out, 0);
        check("arst_q", q_out, 0);
        check("arst_sat", sat_flag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        begin_txn();
        send_bits(32'h00001C00, 32, 1'b0);
        check_result(8'h07, 1'b0, 8'h07, 1'b0);
        release_to_idle(8'h07);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
